// File: rtl/mdi_sift_reader.sv
// Reader side of the MDI one-shot register pair: provisions a round, strobes one read,
// keeps basis-matched pairs in a show-ahead FIFO and tallies matches/discards.
module mdi_sift_reader #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [7:0]       value_a_in,
  input  logic [7:0]       value_b_in,
  input  logic [1:0]       basis_a_in,
  input  logic [1:0]       basis_b_in,
  output logic             init,
  output logic             read,
  output logic [7:0]       value_a,
  output logic [7:0]       value_b,
  output logic [1:0]       basis_a,
  output logic [1:0]       basis_b,
  input  logic [7:0]       out_a,
  input  logic [7:0]       out_b,
  input  logic             pad_enable_a,
  input  logic             pad_enable_b,
  output logic             key_valid,
  input  logic             key_ready,
  output logic [7:0]       key_a,
  output logic [7:0]       key_b,
  output logic             busy,
  output logic             round_done,
  output logic             round_match,
  output logic [CNT_W-1:0] match_count,
  output logic [CNT_W-1:0] discard_count,
  output logic             fifo_full,
  output logic             error
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PROV,
    S_SETTLE,
    S_READ,
    S_DONE
  } state_e;

  state_e state_q, state_d;

  logic [7:0] valA_q, valB_q;
  logic [1:0] basA_q, basB_q;
  logic [7:0] capA_q, capB_q;
  logic       enA_q, enB_q;

  logic [CNT_W-1:0] matchCnt_q, matchCnt_d;
  logic [CNT_W-1:0] discardCnt_q, discardCnt_d;
  logic             error_q, error_d;

  logic [15:0]      mem_q [DEPTH];
  logic [PTR_W-1:0] rdPtr_q, wrPtr_q;
  logic [PTR_W:0]   count_q, count_d;

  logic accept;
  logic keepPair;
  logic splitPair;
  logic push;
  logic pop;

  assign accept    = (state_q == S_IDLE) && start && !fifo_full;
  assign keepPair  = enA_q && enB_q;
  assign splitPair = enA_q ^ enB_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (accept) state_d = S_PROV;
      S_PROV:   state_d = S_SETTLE;
      S_SETTLE: state_d = S_READ;
      S_READ:   state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    init       = 1'b0;
    read       = 1'b0;
    busy       = 1'b1;
    round_done = 1'b0;
    case (state_q)
      S_IDLE:  busy = 1'b0;
      S_PROV:  init = 1'b1;
      S_READ:  read = 1'b1;
      S_DONE:  round_done = 1'b1;
      default: ;
    endcase
  end

  assign round_match = round_done && keepPair;

  // Round inputs are held until the next accepted start; pair returns are captured
  // on the edge that closes READ so DONE can classify them.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valA_q <= '0;
      valB_q <= '0;
      basA_q <= '0;
      basB_q <= '0;
      capA_q <= '0;
      capB_q <= '0;
      enA_q  <= 1'b0;
      enB_q  <= 1'b0;
    end else begin
      if (accept) begin
        valA_q <= value_a_in;
        valB_q <= value_b_in;
        basA_q <= basis_a_in;
        basB_q <= basis_b_in;
      end
      if (state_q == S_READ) begin
        capA_q <= out_a;
        capB_q <= out_b;
        enA_q  <= pad_enable_a;
        enB_q  <= pad_enable_b;
      end
    end
  end

  assign value_a = valA_q;
  assign value_b = valB_q;
  assign basis_a = basA_q;
  assign basis_b = basB_q;

  always_comb begin
    matchCnt_d   = matchCnt_q;
    discardCnt_d = discardCnt_q;
    error_d      = error_q;
    if (state_q == S_DONE) begin
      if (keepPair) begin
        if (matchCnt_q != CNT_MAX) matchCnt_d = matchCnt_q + 1'b1;
      end else begin
        if (discardCnt_q != CNT_MAX) discardCnt_d = discardCnt_q + 1'b1;
        if (splitPair) error_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      matchCnt_q   <= '0;
      discardCnt_q <= '0;
      error_q      <= 1'b0;
    end else begin
      matchCnt_q   <= matchCnt_d;
      discardCnt_q <= discardCnt_d;
      error_q      <= error_d;
    end
  end

  assign match_count   = matchCnt_q;
  assign discard_count = discardCnt_q;
  assign error         = error_q;

  // A start is never accepted while full, so a push can never meet a full FIFO.
  assign push = (state_q == S_DONE) && keepPair;
  assign pop  = key_valid && key_ready;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdPtr_q <= '0;
      wrPtr_q <= '0;
      count_q <= '0;
    end else begin
      count_q <= count_d;
      if (push) wrPtr_q <= wrPtr_q + 1'b1;
      if (pop)  rdPtr_q <= rdPtr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wrPtr_q] <= {capA_q, capB_q};
  end

  assign key_valid = (count_q != '0);
  assign fifo_full = (count_q == FULL_COUNT);
  assign key_a     = key_valid ? mem_q[rdPtr_q][15:8] : 8'h00;
  assign key_b     = key_valid ? mem_q[rdPtr_q][7:0]  : 8'h00;

endmodule

// File: tb/tb_mdi_sift_reader.sv
// Directed + randomized bench for mdi_sift_reader with a behavioural register-pair
// stand-in and a queue-based model of the sifted key stream.
module tb_mdi_sift_reader;

  localparam int DEPTH   = 8;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             resetN;
  logic             start;
  logic [7:0]       valueAIn, valueBIn;
  logic [1:0]       basisAIn, basisBIn;
  logic             initO, readO;
  logic [7:0]       valueA, valueB;
  logic [1:0]       basisA, basisB;
  logic [7:0]       outA, outB;
  logic             padEnA, padEnB;
  logic             keyValid, keyReady;
  logic [7:0]       keyA, keyB;
  logic             busy, roundDone, roundMatch;
  logic [CNT_W-1:0] matchCount, discardCount;
  logic             fifoFull, errorO;

  logic             forceSplit;

  int               testsRun  = 0;
  int               failCount = 0;

  logic [15:0]      expQ[$];
  int               expMatch;
  int               expDiscard;
  bit               expError;

  always #5 clk = ~clk;

  mdi_sift_reader #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .reset_n       (resetN),
    .start         (start),
    .value_a_in    (valueAIn),
    .value_b_in    (valueBIn),
    .basis_a_in    (basisAIn),
    .basis_b_in    (basisBIn),
    .init          (initO),
    .read          (readO),
    .value_a       (valueA),
    .value_b       (valueB),
    .basis_a       (basisA),
    .basis_b       (basisB),
    .out_a         (outA),
    .out_b         (outB),
    .pad_enable_a  (padEnA),
    .pad_enable_b  (padEnB),
    .key_valid     (keyValid),
    .key_ready     (keyReady),
    .key_a         (keyA),
    .key_b         (keyB),
    .busy          (busy),
    .round_done    (roundDone),
    .round_match   (roundMatch),
    .match_count   (matchCount),
    .discard_count (discardCount),
    .fifo_full     (fifoFull),
    .error         (errorO)
  );

  // Register-pair stand-in: during a read both pads open when the bases agree,
  // unless a split (A open, B closed) is being forced.
  always_comb begin
    outA   = 8'h00;
    outB   = 8'h00;
    padEnA = 1'b0;
    padEnB = 1'b0;
    if (readO) begin
      outA = valueA;
      outB = valueB;
      if (forceSplit) begin
        padEnA = 1'b1;
        padEnB = 1'b0;
      end else begin
        padEnA = (basisA == basisB);
        padEnB = (basisA == basisB);
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic checkIdle(input string tag);
    logic [15:0] head;
    head = (expQ.size() != 0) ? expQ[0] : 16'h0000;
    checkOutput({tag, "_busy"}, 32'(busy), 32'(0));
    checkOutput({tag, "_done"}, 32'(roundDone), 32'(0));
    checkOutput({tag, "_match_count"}, 32'(matchCount), 32'(expMatch));
    checkOutput({tag, "_discard_count"}, 32'(discardCount), 32'(expDiscard));
    checkOutput({tag, "_error"}, 32'(errorO), 32'(expError));
    checkOutput({tag, "_key_valid"}, 32'(keyValid), 32'(expQ.size() != 0));
    checkOutput({tag, "_key_pair"}, 32'({keyA, keyB}), 32'(head));
    checkOutput({tag, "_fifo_full"}, 32'(fifoFull), 32'(expQ.size() == DEPTH));
  endtask

  // One full round starting at a falling edge; returns at the falling edge of E+5.
  task automatic applyStimulus(input logic [7:0] va, input logic [7:0] vb,
                               input logic [1:0] ba, input logic [1:0] bb,
                               input bit split, input bit popAtDone,
                               input bit startAtDone);
    bit keep;
    forceSplit = split;
    start      = 1'b1;
    valueAIn   = va;
    valueBIn   = vb;
    basisAIn   = ba;
    basisBIn   = bb;
    @(negedge clk);
    start    = 1'b0;
    valueAIn = 8'($urandom);
    valueBIn = 8'($urandom);
    basisAIn = 2'($urandom);
    basisBIn = 2'($urandom);
    checkOutput("prov_init", 32'(initO), 32'(1));
    checkOutput("prov_read", 32'(readO), 32'(0));
    checkOutput("prov_busy", 32'(busy), 32'(1));
    checkOutput("prov_values", 32'({valueA, valueB}), 32'({va, vb}));
    checkOutput("prov_bases", 32'({basisA, basisB}), 32'({ba, bb}));
    @(negedge clk);
    checkOutput("settle_strobes", 32'({initO, readO}), 32'(0));
    checkOutput("settle_busy", 32'(busy), 32'(1));
    @(negedge clk);
    checkOutput("read_strobe", 32'(readO), 32'(1));
    checkOutput("read_init", 32'(initO), 32'(0));
    @(negedge clk);
    keep = !split && (ba == bb);
    checkOutput("done_pulse", 32'(roundDone), 32'(1));
    checkOutput("done_match", 32'(roundMatch), 32'(keep));
    checkOutput("done_strobes", 32'({initO, readO}), 32'(0));
    if (popAtDone) keyReady = 1'b1;
    if (startAtDone) start = 1'b1;
    if (popAtDone && expQ.size() != 0) void'(expQ.pop_front());
    if (keep) begin
      expQ.push_back({va, vb});
      if (expMatch < CNT_MAX) expMatch++;
    end else begin
      if (expDiscard < CNT_MAX) expDiscard++;
      if (split) expError = 1'b1;
    end
    @(negedge clk);
    keyReady   = 1'b0;
    start      = 1'b0;
    forceSplit = 1'b0;
    checkIdle("round_end");
    checkOutput("held_values", 32'({valueA, valueB}), 32'({va, vb}));
  endtask

  task automatic drainFifo(input int n);
    for (int i = 0; i < n; i++) begin
      checkOutput("drain_valid", 32'(keyValid), 32'(1));
      checkOutput("drain_pair", 32'({keyA, keyB}), 32'(expQ[0]));
      keyReady = 1'b1;
      @(negedge clk);
      void'(expQ.pop_front());
    end
    // Ready held into an empty FIFO must not underflow it.
    keyReady = 1'b1;
    @(negedge clk);
    keyReady = 1'b0;
    checkIdle("drained");
  endtask

  initial begin
    logic [7:0] ra, rb;
    logic [1:0] rba, rbb;

    resetN     = 1'b0;
    start      = 1'b0;
    keyReady   = 1'b0;
    forceSplit = 1'b0;
    valueAIn   = 8'h00;
    valueBIn   = 8'h00;
    basisAIn   = 2'b00;
    basisBIn   = 2'b00;
    expMatch   = 0;
    expDiscard = 0;
    expError   = 1'b0;

    repeat (2) @(negedge clk);
    checkIdle("reset");
    checkOutput("reset_strobes", 32'({initO, readO}), 32'(0));
    checkOutput("reset_values", 32'({valueA, valueB, basisA, basisB}), 32'(0));
    resetN = 1'b1;
    @(negedge clk);

    $display("[TB] matched round");
    applyStimulus(8'h3C, 8'hC3, 2'b01, 2'b01, 1'b0, 1'b0, 1'b0);
    drainFifo(expQ.size());

    $display("[TB] mismatched bases");
    applyStimulus(8'h5A, 8'hA5, 2'b00, 2'b11, 1'b0, 1'b0, 1'b0);

    $display("[TB] pad enable disagreement, start held through DONE");
    applyStimulus(8'h11, 8'h22, 2'b10, 2'b10, 1'b1, 1'b0, 1'b1);

    $display("[TB] simultaneous push and pop at count 3");
    for (int i = 0; i < 3; i++)
      applyStimulus(8'($urandom), 8'($urandom), 2'b11, 2'b11, 1'b0, 1'b0, 1'b0);
    applyStimulus(8'($urandom), 8'($urandom), 2'b10, 2'b10, 1'b0, 1'b1, 1'b0);
    drainFifo(expQ.size());

    $display("[TB] fill, refuse, pop, refill, drain across wrap");
    for (int i = 0; i < DEPTH; i++)
      applyStimulus(8'($urandom), 8'($urandom), 2'b01, 2'b01, 1'b0, 1'b0, 1'b0);
    start = 1'b1;
    repeat (2) begin
      @(negedge clk);
      checkOutput("full_refuse_busy", 32'(busy), 32'(0));
      checkOutput("full_refuse_init", 32'(initO), 32'(0));
    end
    start = 1'b0;
    checkOutput("full_head", 32'({keyA, keyB}), 32'(expQ[0]));
    keyReady = 1'b1;
    @(negedge clk);
    keyReady = 1'b0;
    void'(expQ.pop_front());
    checkOutput("full_after_pop", 32'(fifoFull), 32'(0));
    applyStimulus(8'($urandom), 8'($urandom), 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    drainFifo(expQ.size());

    $display("[TB] randomized rounds with counter saturation");
    for (int i = 0; i < 28; i++) begin
      ra  = 8'($urandom);
      rb  = 8'($urandom);
      rba = 2'($urandom_range(0, 3));
      rbb = 2'($urandom_range(0, 3));
      applyStimulus(ra, rb, rba, rbb, 1'b0, 1'b1, 1'b0);
    end
    for (int i = 0; i < 6; i++)
      applyStimulus(8'($urandom), 8'($urandom), 2'b01, 2'b10, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++)
      applyStimulus(8'($urandom), 8'($urandom), 2'b11, 2'b11, 1'b0, 1'b1, 1'b0);
    drainFifo(expQ.size());

    $display("[TB] reset during READ");
    applyStimulus(8'h01, 8'h02, 2'b01, 2'b01, 1'b0, 1'b0, 1'b0);
    applyStimulus(8'h03, 8'h04, 2'b01, 2'b01, 1'b0, 1'b0, 1'b0);
    start    = 1'b1;
    valueAIn = 8'h77;
    valueBIn = 8'h88;
    basisAIn = 2'b10;
    basisBIn = 2'b10;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("pre_reset_read", 32'(readO), 32'(1));
    #2 resetN = 1'b0;
    #1;
    expQ.delete();
    expMatch   = 0;
    expDiscard = 0;
    expError   = 1'b0;
    checkOutput("async_reset_read", 32'(readO), 32'(0));
    checkIdle("async_reset");
    @(negedge clk);
    resetN = 1'b1;
    @(negedge clk);
    applyStimulus(8'h3C, 8'hC3, 2'b01, 2'b01, 1'b0, 1'b0, 1'b0);
    drainFifo(expQ.size());

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
